dmem_responder: RTL and testbench

- Multi-cycle data-memory responder that services the pipeline's memory stage over a valid/ready request channel.
- Inputs per request: address, store data, write enable and access size. Output: a single-cycle response carrying the unshifted, aligned 32-bit word.
- Replaces the zero-latency combinational data memory so stall logic in the pipeline can be exercised with realistic latency.
- Storage array is named mem, so benches preload it with $readmemh from data.hex.

---
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for the pipeline memory stage. A request
//   is accepted in IDLE, held for LATENCY cycles (WAIT, then RESP), and answered
//   with a one-cycle response strobe. Loads return the full aligned word, with
//   no shifting and no sign extension. Stores merge the selected big-endian
//   lanes into the stored word on the edge that leaves RESP.
//
//   Handshake: a request transfers on a rising edge where req_valid && req_ready
//   are both high and reset is low. req_ready depends only on state, never on
//   req_valid. Request inputs are ignored whenever req_ready is low.
//
//   Optional feature: define MISALIGN_TRAP_EN to flag misaligned halfword and
//   word accesses as faults. These faults return err=1 and rdata=0, and their
//   stores are suppressed.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   addr        byte address
//   wdata       store data, right-justified
//   mem_wr      1 = store, 0 = load
//   data_size   00 byte, 01 halfword, 10/11 word
//   rdata       aligned unshifted word for loads, 0 for stores and faults
//   rdata_valid one-cycle response strobe
//   err         access faulted (qualified by rdata_valid)
//   dbgState    current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic [1:0]  data_size,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic [1:0]  dbgState
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateE;

    stateE       state, nextState;
    logic [3:0]  latCnt, nextLatCnt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] addrQ, wdataQ;
    logic        wrQ;
    logic [1:0]  sizeQ;

    logic             accept;
    logic [IDX_W-1:0] wordIdx;
    logic             outOfRange, misalign, fault;
    logic [31:0]      oldWord, mergedWord;

    assign accept = req_valid && req_ready;

    // State register and latency counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            latCnt <= '0;
        end else begin
            state  <= nextState;
            latCnt <= nextLatCnt;
        end
    end

    // Request capture. Reset blocks the capture so that a request presented
    // during reset is never taken.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            addrQ  <= addr;
            wdataQ <= wdata;
            wrQ    <= mem_wr;
            sizeQ  <= data_size;
        end
    end

    // Next-state logic
    always_comb begin
        nextState  = state;
        nextLatCnt = latCnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        nextState = RESP;
                    end else begin
                        nextState  = WAIT;
                        nextLatCnt = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                nextLatCnt = latCnt - 4'd1;
                if (latCnt == 4'd1) nextState = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Fault decode on the captured request
    assign wordIdx    = addrQ[IDX_W+1:2];
    assign outOfRange = |(addrQ >> (IDX_W + 2));
`ifdef MISALIGN_TRAP_EN
    assign misalign = ((sizeQ == 2'b01) && addrQ[0]) ||
                      (sizeQ[1] && (addrQ[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign fault = outOfRange || misalign;

    // Store merge. Lane 0 is the most significant byte (big-endian).
    assign oldWord = mem[wordIdx];
    always_comb begin
        mergedWord = oldWord;
        case (sizeQ)
            2'b00: begin
                case (addrQ[1:0])
                    2'd0:    mergedWord[31:24] = wdataQ[7:0];
                    2'd1:    mergedWord[23:16] = wdataQ[7:0];
                    2'd2:    mergedWord[15:8]  = wdataQ[7:0];
                    default: mergedWord[7:0]   = wdataQ[7:0];
                endcase
            end
            2'b01: begin
                if (addrQ[1]) mergedWord[15:0]  = wdataQ[15:0];
                else          mergedWord[31:16] = wdataQ[15:0];
            end
            default: mergedWord = wdataQ;
        endcase
    end

    // The commit happens on the edge that leaves RESP, so a load accepted
    // afterwards sees the merged word. Reset in RESP discards the store.
    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && wrQ && !fault) begin
            mem[wordIdx] <= mergedWord;
        end
    end

    // Output logic
    always_comb begin
        req_ready   = (state == IDLE);
        rdata_valid = (state == RESP);
        err         = (state == RESP) && fault;
        rdata       = ((state == RESP) && !wrQ && !fault) ? oldWord : 32'h0;
        dbgState    = state;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic        req_valid, req_ready, mem_wr, rdata_valid, err;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  data_size, dbg_state;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .mem_wr(mem_wr), .data_size(data_size),
    .rdata(rdata), .rdata_valid(rdata_valid), .err(err), .dbgState(dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        wr;
    logic [1:0]  sz;
  } req_t;

  function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
    bit f;
    f = (a >= 32'(DEPTH * 4));
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1 && (a % 2) != 0) f = 1'b1;
    if (sz >= 2'd2 && (a % 4) != 0) f = 1'b1;
`else
    if (sz == 2'd3) f = f;
`endif
    return f;
  endfunction

  // Byte-array view: byte 0 is the most significant byte of the word.
  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] sz);
    logic [7:0]  b [4];
    logic [31:0] res;
    int          base, hb;
    for (int i = 0; i < 4; i++) b[i] = old[31 - 8*i -: 8];
    base = int'(a % 4);
    if (sz == 2'd0) begin
      b[base] = d[7:0];
    end else if (sz == 2'd1) begin
      hb = (base / 2) * 2;
      b[hb]     = d[15:8];
      b[hb + 1] = d[7:0];
    end else begin
      for (int i = 0; i < 4; i++) b[i] = d[31 - 8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 4; i++) res[31 - 8*i -: 8] = b[i];
    return res;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [32:0] exp_q[$];   // {err, rdata}
  int          acc_q[$];
  req_t        pend_q[$];
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_resp_cycle = 0;
  int          resp_count = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      pend_q.delete();
    end else begin
      check("ready", req_ready, exp_q.size() == 0);
      if (rdata_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", rdata_valid, 1'b0);
        end else begin
          logic [32:0] e;
          int          acc;
          req_t        p;
          e = exp_q.pop_front();
          acc = acc_q.pop_front();
          p = pend_q.pop_front();
          check("latency", cycle - acc, LAT);
          check("rdata", rdata, e[31:0]);
          check("err", err, e[32]);
          if (p.wr && !model_fault(p.a, p.sz))
            model_mem[p.a / 4] = model_store(model_mem[p.a / 4], p.a, p.d, p.sz);
          last_rdata = rdata;
          last_err = err;
          last_resp_cycle = cycle;
          resp_count++;
        end
      end else if (acc_q.size() > 0 && (cycle - acc_q[0]) > LAT) begin
        check("resp_timeout", rdata_valid, 1'b1);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        void'(pend_q.pop_front());
      end
      if (req_valid && req_ready) begin
        req_t r;
        bit   f;
        r.a = addr; r.d = wdata; r.wr = mem_wr; r.sz = data_size;
        f = model_fault(addr, data_size);
        exp_q.push_back({f, (f || mem_wr) ? 32'h0 : model_mem[(addr / 4) % DEPTH]});
        acc_q.push_back(cycle);
        pend_q.push_back(r);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Caller is positioned just after a rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic wr,
                      input logic [1:0] sz, input bit keep, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    req_valid = 1'b1; addr = a; wdata = d; mem_wr = wr; data_size = sz;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (req_ready && !reset) begin
        done = 1'b1;
        acc = cycle;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", done, 1'b1);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", idle, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input logic [1:0] sz);
    int acc;
    send(a, d, wr, sz, 1'b0, acc);
    wait_idle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc1, acc2, acc3, cnt0;
    reset = 1'b1;
    req_valid = 1'b0; addr = '0; wdata = '0; mem_wr = 1'b0; data_size = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      dut.mem[i] = v;
      model_mem[i] = v;
    end
    dut.mem[0] = 32'h01020304; model_mem[0] = 32'h01020304;
    dut.mem[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;
    dut.mem[8] = 32'h55667788; model_mem[8] = 32'h55667788;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_valid", rdata_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: word load with latency check
    send(32'h10, 32'h0, 1'b0, 2'd2, 1'b0, acc1);
    wait_idle();
    check("t1_rdata", last_rdata, 32'hDEADBEEF);
    check("t1_err", last_err, 1'b0);
    check("t1_latency", last_resp_cycle - acc1, 2);

    // 2: byte and halfword merges
    do_op(32'h10, 32'h11223344, 1'b1, 2'd2);
    do_op(32'h11, 32'h000000AA, 1'b1, 2'd0);
    do_op(32'h10, 32'h0, 1'b0, 2'd2);
    check("t2_byte_merge", last_rdata, 32'h11AA3344);
    do_op(32'h12, 32'h0000BEEF, 1'b1, 2'd1);
    do_op(32'h10, 32'h0, 1'b0, 2'd2);
    check("t2_half_merge", last_rdata, 32'h11AABEEF);

    // 3: back-to-back loads with req_valid held high
    cnt0 = resp_count;
    send(32'h10, 32'h0, 1'b0, 2'd2, 1'b1, acc1);
    send(32'h20, 32'h0, 1'b0, 2'd2, 1'b1, acc2);
    send(32'h00, 32'h0, 1'b0, 2'd2, 1'b0, acc3);
    wait_idle();
    check("t3_spacing_a", acc2 - acc1, LAT + 1);
    check("t3_spacing_b", acc3 - acc2, LAT + 1);
    check("t3_resp_count", resp_count - cnt0, 3);
    check("t3_last_rdata", last_rdata, 32'h01020304);

    // 4: out-of-range load and store
    do_op(32'h1000, 32'h0, 1'b0, 2'd2);
    check("t4_load_err", last_err, 1'b1);
    check("t4_load_rdata", last_rdata, 32'h0);
    do_op(32'h1000, 32'hFFFFFFFF, 1'b1, 2'd2);
    check("t4_store_err", last_err, 1'b1);
    do_op(32'h0, 32'h0, 1'b0, 2'd2);
    check("t4_mem0_kept", last_rdata, 32'h01020304);

    // 5: reset during WAIT discards a store
    cnt0 = resp_count;
    send(32'h20, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, acc1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_ready_after_reset", req_ready, 1'b1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_response", resp_count - cnt0, 0);
    do_op(32'h20, 32'h0, 1'b0, 2'd2);
    check("t5_mem8_kept", last_rdata, 32'h55667788);

    // reset and req_valid together: the request must not be taken
    cnt0 = resp_count;
    reset = 1'b1;
    req_valid = 1'b1; addr = 32'h10; mem_wr = 1'b0; data_size = 2'd2;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_vs_valid", resp_count - cnt0, 0);

    // 6: misaligned word load
    do_op(32'h22, 32'h0, 1'b0, 2'd2);
`ifdef MISALIGN_TRAP_EN
    check("t6_err", last_err, 1'b1);
    check("t6_rdata", last_rdata, 32'h0);
`else
    check("t6_err", last_err, 1'b0);
    check("t6_rdata", last_rdata, 32'h55667788);
`endif

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int          acc;
      bit          keep;
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 255);
      else a = $urandom_range(0, 63);
      keep = ($urandom_range(0, 1) == 1) && (i != 299);
      send(a, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), keep, acc);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    for (int w = 0; w < 16; w++) do_op(32'(w * 4), 32'h0, 1'b0, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
